// File: rtl/int_bit_manip_pkg.sv
// Shared definitions for the integer bit-manipulation unit: operation
// encoding and the default operand width.
package int_bit_manip_pkg;

  localparam int WIDTH_DEFAULT = 64;
  localparam int OP_W          = 3;

  typedef enum logic [OP_W-1:0] {
    OP_CLR    = 3'b000,
    OP_SET    = 3'b001,
    OP_GET    = 3'b010,
    OP_LOAD   = 3'b011,
    OP_TGL    = 3'b100,
    OP_POPCNT = 3'b101,
    OP_CTZ    = 3'b110,
    OP_BREV   = 3'b111
  } op_e;

endpackage

// File: rtl/bit_count_unit.sv
// Combinational population count and count-trailing-zeros for a WIDTH-bit
// word. CTZ of an all-zero word reports WIDTH, which is why the count width
// is one bit wider than a bit index.
module bit_count_unit
  import int_bit_manip_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic [WIDTH-1:0] data_i,
  output logic [CNT_W-1:0] popcnt_o,
  output logic [CNT_W-1:0] ctz_o
);

  // Sum of set bits across the word.
  always_comb begin
    popcnt_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      popcnt_o = popcnt_o + CNT_W'(data_i[i]);
    end
  end

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    ctz_o = CNT_W'(WIDTH);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (data_i[i]) begin
        ctz_o = CNT_W'(i);
      end
    end
  end

endmodule

// File: rtl/int_bit_manip_unit.sv
// Integer bit-manipulation unit: single-bit clear/set/get/toggle, load,
// popcount, count-trailing-zeros and bit reverse, with a one-cycle registered
// result and no other state.
// Macro INT_BIT_MANIP_EXT_OPS_EN enables codes 100..111 (TGL, POPCNT, CTZ,
// BREV); without it those codes return zero and the counting logic is absent.
module int_bit_manip_unit
  import int_bit_manip_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OP_W-1:0]  operation,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic [WIDTH-1:0] out
);

  op_e              op;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] out_q;

  // Only the low index bits of opb select a bit; the rest are don't-care.
  logic             unused_opb_hi;

  assign op            = op_e'(operation);
  assign idx           = opb[IDX_W-1:0];
  assign unused_opb_hi = ^opb[WIDTH-1:IDX_W];
  assign mask          = {{(WIDTH-1){1'b0}}, 1'b1} << idx;

`ifdef INT_BIT_MANIP_EXT_OPS_EN
  localparam int CNT_W = IDX_W + 1;

  logic [CNT_W-1:0] popcnt;
  logic [CNT_W-1:0] ctz;
  logic [WIDTH-1:0] brev;

  bit_count_unit #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_bit_count (
    .data_i   (opa),
    .popcnt_o (popcnt),
    .ctz_o    (ctz)
  );

  // Bit reverse is pure wiring.
  always_comb begin
    brev = '0;
    for (int i = 0; i < WIDTH; i++) begin
      brev[i] = opa[WIDTH-1-i];
    end
  end
`endif

  // Result mux; anything not explicitly decoded yields zero.
  always_comb begin
    out_d = '0;
    unique case (op)
      OP_CLR:    out_d = opa & ~mask;
      OP_SET:    out_d = opa | mask;
      OP_GET:    out_d[0] = opa[idx];
      OP_LOAD:   out_d = opa;
`ifdef INT_BIT_MANIP_EXT_OPS_EN
      OP_TGL:    out_d = opa ^ mask;
      OP_POPCNT: out_d = {{(WIDTH-CNT_W){1'b0}}, popcnt};
      OP_CTZ:    out_d = {{(WIDTH-CNT_W){1'b0}}, ctz};
      OP_BREV:   out_d = brev;
`endif
      default:   out_d = '0;
    endcase
  end

  // Output register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_int_bit_manip_unit.sv
// Self-checking bench for int_bit_manip_unit at WIDTH = 64. Expected values
// come from a plain arithmetic reference model of the operation set.
module tb_int_bit_manip_unit;

  localparam int W = 64;

  logic         clk;
  logic         rst;
  logic [2:0]   operation;
  logic [W-1:0] opa;
  logic [W-1:0] opb;
  logic [W-1:0] out;

  int n_cmp;
  int n_err;

  int_bit_manip_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .operation (operation),
    .opa       (opa),
    .opb       (opb),
    .out       (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_model(input logic [2:0] op,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    int          k;
    int          cnt;
    logic [W-1:0] bit_k;
    logic [W-1:0] r;
    k     = int'(b % W);
    bit_k = 64'd1 << k;
    r     = '0;
    case (op)
      3'd0: r = a & ~bit_k;
      3'd1: r = a | bit_k;
      3'd2: r = (a >> k) & 64'd1;
      3'd3: r = a;
`ifdef INT_BIT_MANIP_EXT_OPS_EN
      3'd4: r = a ^ bit_k;
      3'd5: begin
        cnt = 0;
        for (int j = 0; j < W; j++) if (((a >> j) & 64'd1) != 0) cnt++;
        r = 64'(cnt);
      end
      3'd6: begin
        cnt = 0;
        while (cnt < W && ((a >> cnt) & 64'd1) == 0) cnt++;
        r = 64'(cnt);
      end
      3'd7: for (int j = 0; j < W; j++) if (((a >> j) & 64'd1) != 0) r = r | (64'd1 << (W-1-j));
`endif
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b0; operation = 3'b011; opa = '1; opb = '0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (out !== 64'd0) begin
        n_err++;
        $display("FAIL reset_hold cycle %0d: got %h want %h", c, out, 64'd0);
      end
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (out !== {W{1'b1}}) begin
      n_err++;
      $display("FAIL reset_release: got %h want %h", out, {W{1'b1}});
    end
  endtask

  task automatic test_directed();
    logic [2:0]   ops [4] = '{3'd0, 3'd1, 3'd2, 3'd2};
    logic [W-1:0] as  [4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'h100, 64'h100};
    logic [W-1:0] bs  [4] = '{64'h3F, 64'h1C0, 64'd8, 64'd9};
    logic [W-1:0] exp_v [4] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h1, 64'h0};
    for (int t = 0; t < 4; t++) begin
      operation = ops[t]; opa = as[t]; opb = bs[t];
      @(posedge clk); #1;
      n_cmp++;
      if (out !== exp_v[t]) begin
        n_err++;
        $display("FAIL directed_%0d op %0d: got %h want %h", t, ops[t], out, exp_v[t]);
      end
    end
  endtask

  task automatic test_ext_ops();
`ifdef INT_BIT_MANIP_EXT_OPS_EN
    logic [2:0]   ops [5] = '{3'd5, 3'd6, 3'd6, 3'd7, 3'd4};
    logic [W-1:0] as  [5] = '{64'hF0F0, 64'hF0F0, 64'd0, 64'd1, 64'd5};
    logic [W-1:0] exp_v [5] = '{64'd8, 64'd4, 64'd64, 64'h8000_0000_0000_0000, 64'h4};
`else
    logic [2:0]   ops [5] = '{3'd5, 3'd3, 3'd6, 3'd7, 3'd4};
    logic [W-1:0] as  [5] = '{64'hF0F0, 64'hF0F0, 64'd0, 64'd1, 64'd5};
    logic [W-1:0] exp_v [5] = '{64'd0, 64'hF0F0, 64'd0, 64'd0, 64'd0};
`endif
    for (int t = 0; t < 5; t++) begin
      operation = ops[t]; opa = as[t]; opb = '0;
      @(posedge clk); #1;
      n_cmp++;
      if (out !== exp_v[t]) begin
        n_err++;
        $display("FAIL ext_op_%0d op %0d: got %h want %h", t, ops[t], out, exp_v[t]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]   ops [3] = '{3'd1, 3'd0, 3'd2};
    logic [W-1:0] as  [3] = '{64'h0, 64'hFFFF, 64'h8000_0000_0000_0000};
    logic [W-1:0] bs  [3] = '{64'd5, 64'd3, 64'd63};
    logic [W-1:0] exp_v [3] = '{64'h20, 64'hFFF7, 64'h1};
    for (int t = 0; t < 3; t++) begin
      operation = ops[t]; opa = as[t]; opb = bs[t];
      @(posedge clk); #1;
      n_cmp++;
      if (out !== exp_v[t]) begin
        n_err++;
        $display("FAIL back_to_back_%0d: got %h want %h", t, out, exp_v[t]);
      end
    end
  endtask

  task automatic test_reset_midstream();
    operation = 3'd3; opa = 64'hDEAD_BEEF_0123_4567; opb = '0;
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (out !== 64'd0) begin
      n_err++;
      $display("FAIL reset_midstream_discard: got %h want %h", out, 64'd0);
    end
    rst = 1'b1; opa = 64'h0000_0000_CAFE_F00D;
    @(posedge clk); #1;
    n_cmp++;
    if (out !== 64'h0000_0000_CAFE_F00D) begin
      n_err++;
      $display("FAIL reset_midstream_first: got %h want %h", out, 64'h0000_0000_CAFE_F00D);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] e;
    for (int t = 0; t < 400; t++) begin
      operation = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       opa = '0;
        1:       opa = 64'd1 << $urandom_range(0, W-1);
        2:       opa = '1;
        default: opa = {$urandom, $urandom};
      endcase
      opb = {$urandom, $urandom};
      e = ref_model(operation, opa, opb);
      @(posedge clk); #1;
      n_cmp++;
      if (out !== e) begin
        n_err++;
        $display("FAIL random_%0d op %0d a %h b %h: got %h want %h", t, operation, opa, opb, out, e);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0; operation = '0; opa = '0; opb = '0;
    @(posedge clk); #1;
    test_reset();
    test_directed();
    test_ext_ops();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/int_bit_manip_unit.md
INT_BIT_MANIP_UNIT -- requirements
Module: int_bit_manip_unit

Interface
REQ-001 Parameter: WIDTH, 64, operand/result width in bits; SHALL be a power of two, 16..64.
REQ-002 Parameter: IDX_W, $clog2(WIDTH), width of the bit-index field taken from opb.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 operation  input  3  operation select, encoding per REQ-010..REQ-017.
REQ-006 opa  input  WIDTH  data operand.
REQ-007 opb  input  WIDTH  index operand; only opb[IDX_W-1:0] is used, upper bits SHALL be ignored.
REQ-008 out  output  WIDTH  registered result.

Function
REQ-009 idx = opb[IDX_W-1:0]; mask = one-hot bit at position idx, all other bits 0.
REQ-010 000 CLR: out <= opa with bit idx forced to 0, other bits unchanged.
REQ-011 001 SET: out <= opa with bit idx forced to 1, other bits unchanged.
REQ-012 010 GET: out <= zero-extended opa[idx], i.e. out[0] = opa[idx], out[WIDTH-1:1] = 0.
REQ-013 011 LOAD: out <= opa, a pass-through used to set the output directly.
REQ-014 100 TGL: out <= opa XOR mask.
REQ-015 101 POPCNT: out <= number of 1 bits in opa, zero-extended.
REQ-016 110 CTZ: out <= index of the lowest set bit of opa, zero-extended; opa == 0 SHALL give out = WIDTH.
REQ-017 111 BREV: out[i] <= opa[WIDTH-1-i] for all i.
REQ-018 Latency: exactly 1 cycle; inputs sampled at edge N give the result on out after edge N.
REQ-019 No enable or handshake: out SHALL update on every rising edge while rst = 1; back-to-back operations are fully pipelined at one per cycle.
REQ-020 Operation is purely combinational before the single output register; no other internal state SHALL exist.
REQ-021 X/undefined operation codes are not a case; all 8 encodings are defined (see REQ-024 for compiled-out codes).

Reset
REQ-022 At a rising clk edge with rst = 0, out SHALL become all zeros, regardless of operation or operands.
REQ-023 Reset mid-stream: the result of the operation sampled at the reset edge SHALL be discarded; the first result after release appears one cycle after the first edge with rst = 1.

Configuration
REQ-024 Macro INT_BIT_MANIP_EXT_OPS_EN: when defined, codes 100..111 behave per REQ-014..REQ-017; when undefined, those codes SHALL produce out = 0 and the POPCNT/CTZ/BREV logic SHALL NOT be synthesized. Codes 000..011 are unaffected either way.

Structure
REQ-025 Shared package int_bit_manip_pkg SHALL hold the 3-bit operation enum (OP_CLR, OP_SET, OP_GET, OP_LOAD, OP_TGL, OP_POPCNT, OP_CTZ, OP_BREV) and default WIDTH constant.
REQ-026 One sub-module, bit_count_unit, SHALL compute POPCNT and CTZ combinationally for a WIDTH-bit input; it is instantiated only under INT_BIT_MANIP_EXT_OPS_EN.
REQ-027 Top level contains operation decode, mask generation, result mux and output register.

Verification (WIDTH = 64)
REQ-028 rst = 0 for 2 cycles with opa = all-ones, operation = 011 -> out = 0x0000_0000_0000_0000; release -> out = 0xFFFF_FFFF_FFFF_FFFF one cycle later.
REQ-029 opa = 0xFFFF_FFFF_FFFF_FFFF, opb = 0x3F, op 000 -> out = 0x7FFF_FFFF_FFFF_FFFF; opa = 0, opb = 0x1C0 (idx 0, upper bits ignored), op 001 -> out = 0x1.
REQ-030 opa = 0x0000_0000_0000_0100, opb = 8, op 010 -> out = 1; opb = 9 -> out = 0.
REQ-031 Macro defined: opa = 0xF0F0, op 101 -> out = 8; op 110 -> out = 4; opa = 0, op 110 -> out = 64; opa = 0x1, op 111 -> out = 0x8000_0000_0000_0000; opa = 0x5, opb = 0, op 100 -> out = 0x4.
REQ-032 Macro undefined: opa = 0xF0F0, op 101 -> out = 0; op 011 still returns 0xF0F0.
REQ-033 Back-to-back: ops 001, 000, 010 on consecutive cycles -> three distinct correct results on three consecutive cycles with no bubbles.
